// File: rtl/ahb_flash_access_ctrl.sv
// ============================================================================
// Module   : ahb_flash_access_ctrl
// Purpose  : AHB-Lite read-only flash slave with wait states and a one-word line buffer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_flash_access_ctrl #(
    parameter int AW = 16,
    parameter int WW = 4
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [AW+1:0] HADDR,
    output logic [31:0]   HRDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    input  logic [WW-1:0] cfg_wait,
    input  logic          flush,
    output logic          FLASH_CS,
    output logic [AW-1:0] FLASH_ADDR,
    input  logic [31:0]   FLASH_RDATA,
    output logic          buf_hit
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        DONE = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [31:0]   buf_data;
    logic [AW-1:0] buf_tag;
    logic          buf_valid;
    logic          flush_pend;

    logic          accept;
    logic [AW-1:0] waddr;
    logic          lookup_hit;
    logic          unused_bits;

    assign accept      = HSEL & HREADY & HTRANS[1];
    assign waddr       = HADDR[AW+1:2];
    assign lookup_hit  = buf_valid && (buf_tag == waddr);
    assign unused_bits = ^{HTRANS[0], HADDR[1:0]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= IDLE;
            HREADYOUT  <= 1'b1;
            HRESP      <= 1'b0;
            HRDATA     <= '0;
            FLASH_CS   <= 1'b0;
            FLASH_ADDR <= '0;
            buf_hit    <= 1'b0;
            buf_valid  <= 1'b0;
            buf_tag    <= '0;
            buf_data   <= '0;
            wait_cnt   <= '0;
            flush_pend <= 1'b0;
        end else begin
            buf_hit <= 1'b0;
            case (state)
                FILL: begin
                    if (wait_cnt == '0) begin
                        // A flush seen at any point of the fill leaves the captured word invalid
                        buf_data  <= FLASH_RDATA;
                        buf_tag   <= FLASH_ADDR;
                        buf_valid <= ~(flush | flush_pend);
                        HRDATA    <= FLASH_RDATA;
                        HREADYOUT <= 1'b1;
                        FLASH_CS  <= 1'b0;
                        state     <= DONE;
                    end else begin
                        wait_cnt   <= wait_cnt - 1'b1;
                        flush_pend <= flush_pend | flush;
                    end
                end
                ERR1: begin
                    HREADYOUT <= 1'b1;
                    state     <= ERR2;
                    if (flush) buf_valid <= 1'b0;
                end
                default: begin
                    // IDLE, DONE and ERR2 are all completion-capable cycles
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    FLASH_CS  <= 1'b0;
                    state     <= IDLE;
                    if (flush) buf_valid <= 1'b0;
                    if (accept) begin
                        if (HWRITE) begin
                            state     <= ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (lookup_hit) begin
                            HRDATA  <= buf_data;
                            buf_hit <= 1'b1;
                        end else begin
                            state      <= FILL;
                            HREADYOUT  <= 1'b0;
                            FLASH_CS   <= 1'b1;
                            FLASH_ADDR <= waddr;
                            wait_cnt   <= cfg_wait;
                            flush_pend <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb_flash_access_ctrl.sv
// ============================================================================
// Module   : tb_ahb_flash_access_ctrl
// Purpose  : Self-checking bench: beat-queue reference model, directed and random traffic
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_flash_access_ctrl;
    localparam int AW = 16;
    localparam int WW = 4;

    logic          HCLK = 1'b0;
    logic          HRESET, HSEL, HREADY, HWRITE, flush;
    logic [1:0]    HTRANS;
    logic [AW+1:0] HADDR;
    logic [31:0]   HRDATA, FLASH_RDATA;
    logic          HREADYOUT, HRESP, FLASH_CS, buf_hit;
    logic [WW-1:0] cfg_wait;
    logic [AW-1:0] FLASH_ADDR;

    always #5 HCLK = ~HCLK;

    ahb_flash_access_ctrl #(.AW(AW), .WW(WW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HADDR(HADDR), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .cfg_wait(cfg_wait), .flush(flush),
        .FLASH_CS(FLASH_CS), .FLASH_ADDR(FLASH_ADDR), .FLASH_RDATA(FLASH_RDATA),
        .buf_hit(buf_hit)
    );

    // One entry per expected data-phase cycle; an empty queue means an idle OKAY cycle
    typedef struct packed {
        logic          ready;
        logic          resp;
        logic          hit;
        logic          cs;
        logic          cap;
        logic          has_data;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } beat_t;

    beat_t         q[$];
    beat_t         ce;
    logic          m_valid;
    logic [AW-1:0] m_tag;
    logic [31:0]   m_data;
    logic [31:0]   last_rdata;
    logic [31:0]   fmem [logic [AW-1:0]];
    int            checks = 0;
    int            errors = 0;
    bit            run = 0;

    function automatic logic [31:0] mem(input logic [AW-1:0] a);
        if (fmem.exists(a)) return fmem[a];
        return {a ^ 16'hA5C3, ~a};
    endfunction

    function automatic beat_t mk(input logic r, input logic s, input logic h, input logic c,
                                 input logic p, input logic d, input logic [AW-1:0] ad,
                                 input logic [31:0] dt);
        beat_t b;
        b.ready = r; b.resp = s; b.hit = h; b.cs = c;
        b.cap = p; b.has_data = d; b.addr = ad; b.data = dt;
        return b;
    endfunction

    function automatic beat_t front();
        if (q.size() != 0) return q[0];
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        beat_t         cur;
        logic [AW-1:0] a;
        bit            newfill;
        if (HRESET) begin
            q.delete();
            m_valid = 1'b0; m_tag = '0; m_data = '0; last_rdata = '0;
        end else begin
            cur     = front();
            newfill = 0;
            if (q.size() != 0) begin
                q.delete(0);
                if (cur.has_data) last_rdata = cur.data;
            end
            if (HSEL && cur.ready && HTRANS[1]) begin
                a = HADDR[AW+1:2];
                if (HWRITE) begin
                    q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
                    q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
                end else if (m_valid && m_tag == a) begin
                    q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, m_data));
                end else begin
                    for (int i = 0; i <= int'(cfg_wait); i++)
                        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, (i == int'(cfg_wait)), 1'b0, a, '0));
                    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, mem(a)));
                    m_tag = a; m_data = mem(a); m_valid = 1'b1; newfill = 1;
                end
            end
            if (flush && !newfill) m_valid = 1'b0;
        end
    endtask

    task automatic step();
        beat_t f;
        @(posedge HCLK);
        model_edge();
        #1;
        f           = front();
        HREADY      = f.ready;
        // Only the final fill cycle carries real flash data; earlier cycles are noise
        FLASH_RDATA = (f.cs && f.cap) ? mem(f.addr) : $urandom();
        @(negedge HCLK);
    endtask

    always @(negedge HCLK) begin
        if (run) begin
            ce = front();
            chk("hreadyout", {31'd0, HREADYOUT}, {31'd0, ce.ready});
            chk("hresp", {31'd0, HRESP}, {31'd0, ce.resp});
            chk("buf_hit", {31'd0, buf_hit}, {31'd0, ce.hit});
            chk("flash_cs", {31'd0, FLASH_CS}, {31'd0, ce.cs});
            chk("hrdata", HRDATA, ce.has_data ? ce.data : last_rdata);
            if (ce.cs) chk("flash_addr", {16'd0, FLASH_ADDR}, {16'd0, ce.addr});
        end
    end

    task automatic set_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic set_xfer(input logic w, input logic [AW+1:0] ad);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = ad;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (HREADYOUT !== 1'b1 && n < 40) begin
            n++;
            step();
        end
    endtask

    initial begin
        int            n;
        logic [AW-1:0] w;
        int            r;
        HRESET = 1'b1; flush = 1'b0; cfg_wait = 4'd3; HADDR = '0;
        HREADY = 1'b1; FLASH_RDATA = '0;
        set_idle();
        step();
        run = 1;
        step();
        HRESET = 1'b0;
        repeat (3) begin
            step();
            chk("idle_ready", {31'd0, HREADYOUT}, 32'd1);
            chk("idle_resp", {31'd0, HRESP}, 32'd0);
            chk("idle_cs", {31'd0, FLASH_CS}, 32'd0);
        end

        // Miss, cfg_wait=3
        fmem[16'h0004] = 32'hDEADBEEF;
        cfg_wait = 4'd3;
        set_xfer(1'b0, 18'h00010);
        step();
        set_idle();
        n = 0;
        while (HREADYOUT !== 1'b1 && n < 40) begin
            chk("miss_cs", {31'd0, FLASH_CS}, 32'd1);
            chk("miss_addr", {16'd0, FLASH_ADDR}, 32'h0004);
            n++;
            step();
        end
        chk("miss_waits", n, 32'd4);
        chk("miss_data", HRDATA, 32'hDEADBEEF);

        // Back-to-back hits on the same word
        set_xfer(1'b0, 18'h00010);
        step();
        chk("hit1_flag", {31'd0, buf_hit}, 32'd1);
        chk("hit1_data", HRDATA, 32'hDEADBEEF);
        set_xfer(1'b0, 18'h00012);
        step();
        chk("hit2_flag", {31'd0, buf_hit}, 32'd1);
        chk("hit2_ready", {31'd0, HREADYOUT}, 32'd1);
        chk("hit2_cs", {31'd0, FLASH_CS}, 32'd0);
        set_idle();
        step();

        // Write error, buffer preserved
        set_xfer(1'b1, 18'h00020);
        step();
        chk("err1", {30'd0, HREADYOUT, HRESP}, 32'b01);
        set_idle();
        step();
        chk("err2", {30'd0, HREADYOUT, HRESP}, 32'b11);
        set_xfer(1'b0, 18'h00010);
        step();
        chk("err_hit", {31'd0, buf_hit}, 32'd1);
        chk("err_hit_data", HRDATA, 32'hDEADBEEF);
        set_idle();
        step();

        // Flush in the second fill cycle
        cfg_wait = 4'd2;
        fmem[16'h0010] = 32'h12345678;
        set_xfer(1'b0, 18'h00040);
        step();
        set_idle();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_ready(n);
        chk("flush_data", HRDATA, 32'h12345678);
        set_xfer(1'b0, 18'h00040);
        step();
        set_idle();
        wait_ready(n);
        chk("flush_refill", n, 32'd3);
        step();

        // Reset in the middle of a fill
        set_xfer(1'b0, 18'h00080);
        step();
        set_idle();
        step();
        HRESET = 1'b1;
        step();
        chk("rst_cs", {31'd0, FLASH_CS}, 32'd0);
        chk("rst_ready", {31'd0, HREADYOUT}, 32'd1);
        HRESET = 1'b0;
        step();
        set_xfer(1'b0, 18'h00080);
        step();
        chk("rst_miss", {31'd0, HREADYOUT}, 32'd0);
        set_idle();
        wait_ready(n);
        chk("rst_waits", n, 32'd3);

        // Zero wait states
        cfg_wait = 4'd0;
        set_xfer(1'b0, 18'h00200);
        step();
        set_idle();
        wait_ready(n);
        chk("w0_waits", n, 32'd1);
        step();

        // Randomized traffic
        repeat (1500) begin
            if (HRESET) HRESET = 1'b0;
            else if ($urandom_range(0, 299) == 0) HRESET = 1'b1;
            flush    = ($urandom_range(0, 15) == 0);
            cfg_wait = 4'($urandom_range(0, 3));
            if (front().ready) begin
                w = AW'($urandom_range(0, 5));
                if ($urandom_range(0, 4) == 0) w = w ^ (AW'(1) << $urandom_range(1, 15));
                HADDR = {w, 2'($urandom_range(0, 3))};
                r = int'($urandom_range(0, 9));
                if (r == 0) set_idle();
                else if (r == 1) begin
                    HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b0;
                end else if (r == 2) begin
                    HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b0;
                end else if (r == 3) set_xfer(1'b1, HADDR);
                else begin
                    set_xfer(1'b0, HADDR);
                    HTRANS = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahb_flash_access_ctrl.md
Name: ahb_flash_access_ctrl

Overview:
- AHB-Lite read-only slave that sits on the flash target output port of the bus matrix and sequences every access to the single-ported flash macro.
- Inserts a programmable number of wait states and keeps a one-word line buffer, so a repeat read of the same word completes with zero wait.
- Writes are rejected with a two-cycle ERROR response.

Parameters:
- AW, 16, flash word-address width; HADDR[AW+1:2] is the word address.
- WW, 4, width of the wait-state configuration field.

Ports:
- HCLK  in  1  AHB system clock.
- HRESET  in  1  Synchronous, active-high reset.
- HSEL  in  1  Slave select.
- HREADY  in  1  Bus ready; address phase is taken only when it is 1.
- HTRANS  in  2  Transfer type.
- HWRITE  in  1  Write flag.
- HADDR  in  AW+2  Byte address.
- HRDATA  out  32  Read data.
- HREADYOUT  out  1  Slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- cfg_wait  in  WW  Flash wait states N.
- flush  in  1  One-cycle pulse that invalidates the line buffer.
- FLASH_CS  out  1  Flash access strobe.
- FLASH_ADDR  out  AW  Flash word address.
- FLASH_RDATA  in  32  Flash read data.
- buf_hit  out  1  One-cycle pulse on each zero-wait buffer hit.

Behaviour:
- Clocking and reset: single clock (HCLK); reset HRESET is synchronous and active-high.
- Reset values: FSM=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, FLASH_CS=0, FLASH_ADDR=0, buf_hit=0, buffer valid=0, tag=0.
- Address phase accepted = HSEL & HREADY & HTRANS[1]. When accepted, register HWRITE and word address waddr = HADDR[AW+1:2].
- Unselected, IDLE or BUSY transfers: no state change; OKAY with zero wait.
- FSM states: IDLE, FILL, DONE, ERR1, ERR2.
- From IDLE, or from DONE/ERR2/hit completion, when an address phase is accepted:
  - Write -> ERR1.
  - Read with valid=1 and tag==waddr -> hit. Next cycle: HREADYOUT=1, HRDATA=buffer, buf_hit=1. Stay in IDLE.
  - Read miss -> FILL.
- FILL:
  - On entry, load the down-counter with cfg_wait. cfg_wait is sampled only here; changing it mid-fill has no effect on that fill.
  - FLASH_CS=1 and FLASH_ADDR=waddr, both held stable for all N+1 FILL cycles.
  - HREADYOUT=0 throughout FILL.
  - In the FILL cycle where the counter is 0: capture FLASH_RDATA into the buffer, set tag=waddr and valid=1, then go to DONE.
- DONE (one cycle): HREADYOUT=1, HRDATA=buffer, FLASH_CS=0. A new address phase is accepted in this same cycle.
- Miss latency with N wait states: N+1 data-phase cycles with HREADYOUT=0, then one cycle with HREADYOUT=1.
- ERR1: HREADYOUT=0, HRESP=1. Next state ERR2.
- ERR2: HREADYOUT=1, HRESP=1. Buffer is untouched. A new address phase may be accepted here.
- HRESP=0 in all states except ERR1/ERR2.
- Back-to-back transfers: a transfer accepted in the completion cycle of the previous one starts with no bubble.
  - Hit after hit: one zero-wait beat per cycle.
  - Miss after hit: enters FILL directly.
- flush:
  - Clears valid on the next edge.
  - Flush during FILL: the in-flight fill still returns correct data to the master, but valid is forced to 0 after capture (flush wins over fill).
  - Flush in the same cycle as a hit lookup: the lookup uses the pre-flush valid, so that beat is still a hit.
- Tag compare: full AW bits. Word address wraps naturally; no range checking is done.
- HRESET asserted mid-FILL or mid-ERR: return to reset values on the next edge. FLASH_CS drops immediately at that edge and the pending transfer is abandoned.
- HRDATA is held at its last value when not in a completion cycle.

Test Plan:
- Reset then idle: HRESET=1 for 2 cycles, then HTRANS=IDLE -> HREADYOUT=1, HRESP=0, FLASH_CS=0 every cycle.
- Miss with cfg_wait=3:
  - Stimulus: read HADDR=0x0010; FLASH_RDATA=0xDEADBEEF.
  - Required: FLASH_CS=1 with FLASH_ADDR=0x0004 for 4 cycles; HREADYOUT=0 for 4 cycles; then HREADYOUT=1 with HRDATA=0xDEADBEEF.
- Hit:
  - Stimulus: immediately re-read 0x0010, then 0x0012 (same word).
  - Required: both beats zero-wait; HRDATA=0xDEADBEEF; buf_hit=1 on each; FLASH_CS stays 0.
- Write error: write to 0x0020 -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1; buffer still hits on 0x0010 afterwards.
- Flush during fill:
  - Stimulus: cfg_wait=2; read 0x0040 (FLASH_RDATA=0x12345678); pulse flush in the second FILL cycle.
  - Required: master receives 0x12345678; the following read of 0x0040 misses and performs 3 FILL cycles.
- Reset mid-fill and cfg_wait=0:
  - Reset mid-fill: assert HRESET during FILL -> FLASH_CS=0 and HREADYOUT=1 after the edge; the next read of the same address misses.
  - cfg_wait=0: a miss gives exactly 1 wait cycle.
